// File: rtl/mem_pipe_ctrl.sv
// Hazard/sequencing control for the F-D-E-M1-M2-W core: forwarding selects, stall/flush, dmem handshake.
// Latency: all controls are combinational from inputs and FSM state; the handshake FSM updates once per clock.
// Backpressure: dmem_ready low holds F..M1 and bubbles M2, bounded by TIMEOUT. Optional MEM_PIPE_CTRL_PERF_EN adds perf counters.
module mem_pipe_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic [4:0] rd_m1,
    input  logic [4:0] rd_m2,
    input  logic [4:0] rd_w,
    input  logic       reg_write_e,
    input  logic       reg_write_m1,
    input  logic       reg_write_m2,
    input  logic       reg_write_w,
    input  logic [1:0] result_src_e,
    input  logic [1:0] result_src_m1,
    input  logic       mem_write_m1,
    input  logic       pc_src_e,
    input  logic       dmem_ready,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m1,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m2,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       dmem_req,
    output logic       dmem_err
`ifdef MEM_PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_mem_stalls,
    output logic [31:0] perf_flushes
`endif
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             memop;
    logic             hz_e;
    logic             hz_m1;
    logic             hz;
    logic             timeout_hit;
    logic             mstall;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       m1_hit,
        input logic       m2_hit,
        input logic       w_hit
    );
        if (rs == 5'd0)  return 2'b00;
        else if (m1_hit) return 2'b11;
        else if (m2_hit) return 2'b10;
        else if (w_hit)  return 2'b01;
        else             return 2'b00;
    endfunction

    always_comb begin
        forward_a_e = fwd_sel(rs1_e,
                              reg_write_m1 && result_src_m1 == 2'b00 && rd_m1 == rs1_e,
                              reg_write_m2 && rd_m2 == rs1_e,
                              reg_write_w  && rd_w  == rs1_e);
        forward_b_e = fwd_sel(rs2_e,
                              reg_write_m1 && result_src_m1 == 2'b00 && rd_m1 == rs2_e,
                              reg_write_m2 && rd_m2 == rs2_e,
                              reg_write_w  && rd_w  == rs2_e);
    end

    // Any non-ALU result (load or PC+4) still in E or M1 is not yet forwardable to D's consumer.
    always_comb begin
        hz_e  = reg_write_e && result_src_e != 2'b00 && rd_e != 5'd0 &&
                (rd_e == rs1_d || rd_e == rs2_d);
        hz_m1 = reg_write_m1 && result_src_m1 != 2'b00 && rd_m1 != 5'd0 &&
                (rd_m1 == rs1_d || rd_m1 == rs2_d);
        hz    = hz_e || hz_m1;
        memop = result_src_m1 == 2'b01 || mem_write_m1;
    end

    // On timeout the op is released in the same cycle so M1 advances as if it completed.
    always_comb begin
        timeout_hit = state == S_WAIT && !dmem_ready && wait_cnt == CNT_W'(TIMEOUT);
        mstall      = !rst && !dmem_ready &&
                      ((state == S_IDLE && memop) || (state == S_WAIT && !timeout_hit));
        dmem_req    = !rst && (state == S_WAIT || memop);
        stall_f     = mstall || (!rst && hz && !pc_src_e);
        stall_d     = stall_f;
        stall_e     = mstall;
        stall_m1    = mstall;
        flush_m2    = mstall;
        flush_d     = !rst && !mstall && pc_src_e;
        flush_e     = !rst && !mstall && (pc_src_e || hz);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            dmem_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memop && !dmem_ready) begin
                        state    <= S_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ready) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                        dmem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef MEM_PIPE_CTRL_PERF_EN
    logic lu_evt;
    logic fl_evt;

    assign lu_evt = hz && !pc_src_e && !mstall;
    assign fl_evt = pc_src_e && !mstall;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stalls  <= '0;
            perf_mem_stalls <= '0;
            perf_flushes    <= '0;
        end else begin
            if (lu_evt && perf_lu_stalls != '1)
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (mstall && perf_mem_stalls != '1)
                perf_mem_stalls <= perf_mem_stalls + 32'd1;
            if (fl_evt && perf_flushes != '1)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_pipe_ctrl.sv
// Bench for mem_pipe_ctrl: directed literal checks plus randomized traffic against a behavioural model.
module tb_mem_pipe_ctrl;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m1, rd_m2, rd_w;
    logic       reg_write_e, reg_write_m1, reg_write_m2, reg_write_w;
    logic [1:0] result_src_e, result_src_m1;
    logic       mem_write_m1, pc_src_e, dmem_ready;
    logic       stall_f, stall_d, stall_e, stall_m1;
    logic       flush_d, flush_e, flush_m2;
    logic [1:0] forward_a_e, forward_b_e;
    logic       dmem_req, dmem_err;
`ifdef MEM_PIPE_CTRL_PERF_EN
    logic [31:0] perf_lu_stalls, perf_mem_stalls, perf_flushes;
`endif

    mem_pipe_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m1(rd_m1), .rd_m2(rd_m2), .rd_w(rd_w),
        .reg_write_e(reg_write_e), .reg_write_m1(reg_write_m1),
        .reg_write_m2(reg_write_m2), .reg_write_w(reg_write_w),
        .result_src_e(result_src_e), .result_src_m1(result_src_m1),
        .mem_write_m1(mem_write_m1), .pc_src_e(pc_src_e), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m1(stall_m1),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m2(flush_m2),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .dmem_req(dmem_req), .dmem_err(dmem_err)
`ifdef MEM_PIPE_CTRL_PERF_EN
        ,
        .perf_lu_stalls(perf_lu_stalls), .perf_mem_stalls(perf_mem_stalls),
        .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: cycles the current memory op has already been stalled, sticky error, event totals.
    int     pend = 0;
    bit     err  = 1'b0;
    longint p_lu = 0, p_mem = 0, p_fl = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (reg_write_m1 && result_src_m1 == 2'd0 && rd_m1 == rs) return 2'd3;
        if (reg_write_m2 && rd_m2 == rs) return 2'd2;
        if (reg_write_w && rd_w == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit consumes(input logic [4:0] rd, input logic we, input logic [1:0] src);
        return we && src != 2'd0 && rd != 0 && (rd == rs1_d || rd == rs2_d);
    endfunction

    function automatic bit m_hz();
        return consumes(rd_e, reg_write_e, result_src_e) || consumes(rd_m1, reg_write_m1, result_src_m1);
    endfunction

    function automatic bit m_busy();
        return result_src_m1 == 2'd1 || mem_write_m1 || pend > 0;
    endfunction

    function automatic logic [12:0] model_out();
        bit req, ms, sf, fd, fe;
        req = !rst && m_busy();
        ms  = req && !dmem_ready && pend < TO;
        sf  = ms || (!rst && m_hz() && !pc_src_e);
        fd  = !rst && !ms && pc_src_e;
        fe  = !rst && !ms && (pc_src_e || m_hz());
        return {sf, sf, ms, ms, fd, fe, ms, fwd(rs1_e), fwd(rs2_e), req, err};
    endfunction

    task automatic model_check();
        logic [12:0] a;
        a = {stall_f, stall_d, stall_e, stall_m1, flush_d, flush_e, flush_m2,
             forward_a_e, forward_b_e, dmem_req, dmem_err};
        chk("model_outputs", 32'(a), 32'(model_out()));
`ifdef MEM_PIPE_CTRL_PERF_EN
        chk("perf_lu", perf_lu_stalls, 32'(p_lu));
        chk("perf_mem", perf_mem_stalls, 32'(p_mem));
        chk("perf_fl", perf_flushes, 32'(p_fl));
`endif
    endtask

    task automatic model_update();
        bit ms;
        ms = m_busy() && !dmem_ready && pend < TO;
        if (rst) begin
            pend = 0; err = 1'b0; p_lu = 0; p_mem = 0; p_fl = 0;
        end else begin
            if (m_hz() && !pc_src_e && !ms && p_lu < 64'hFFFFFFFF) p_lu++;
            if (ms && p_mem < 64'hFFFFFFFF) p_mem++;
            if (pc_src_e && !ms && p_fl < 64'hFFFFFFFF) p_fl++;
            if (m_busy() && !dmem_ready) begin
                if (pend == TO) begin
                    err  = 1'b1;
                    pend = 0;
                end else begin
                    pend++;
                end
            end else begin
                pend = 0;
            end
        end
    endtask

    task automatic eval();
        #3;
        model_check();
    endtask

    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
        rd_e = 0; rd_m1 = 0; rd_m2 = 0; rd_w = 0;
        reg_write_e = 0; reg_write_m1 = 0; reg_write_m2 = 0; reg_write_w = 0;
        result_src_e = 0; result_src_m1 = 0; mem_write_m1 = 0; pc_src_e = 0;
        dmem_ready = 1;
    endtask

    initial begin
        // Reset with every hazard source active: controls must all be quiet.
        clr();
        rst = 1; rs1_d = 6; rd_e = 6; reg_write_e = 1; result_src_e = 1;
        pc_src_e = 1; mem_write_m1 = 1; dmem_ready = 0;
        @(posedge clk); #1;
        eval();
        chk("rst_ctrl", 32'({stall_f, stall_d, stall_e, stall_m1, flush_d, flush_e, flush_m2, dmem_req}), 0);
        adv();
        clr(); eval();
        chk("rst_err", 32'(dmem_err), 0);
        adv();

        // ALU forwarding chain
        clr();
        rs1_e = 5; rd_m1 = 5; rd_m2 = 5; rd_w = 5;
        reg_write_m1 = 1; reg_write_m2 = 1; reg_write_w = 1;
        eval(); chk("fwd_m1", 32'(forward_a_e), 3); adv();
        reg_write_m1 = 0;
        eval(); chk("fwd_m2", 32'(forward_a_e), 2); adv();
        reg_write_m2 = 0;
        eval(); chk("fwd_w", 32'(forward_a_e), 1); adv();
        reg_write_m1 = 1; reg_write_m2 = 1; result_src_m1 = 2; rs2_e = 5;
        eval(); chk("fwd_m1_pc4", 32'(forward_b_e), 2); adv();
        rs1_e = 0;
        eval(); chk("fwd_x0", 32'(forward_a_e), 0); adv();

        // Load-use: two stall cycles, then consumer forwards from W
        clr(); reg_write_e = 1; result_src_e = 1; rd_e = 6; rs2_d = 6;
        eval(); chk("lu_e", 32'({stall_f, stall_d, flush_e, flush_d}), 'hE); adv();
        clr(); reg_write_m1 = 1; result_src_m1 = 1; rd_m1 = 6; rs2_d = 6;
        eval(); chk("lu_m1", 32'({stall_f, stall_d, flush_e, flush_d, stall_e}), 'h1C); adv();
        clr(); reg_write_m2 = 1; rd_m2 = 6; rs2_d = 6;
        eval(); chk("lu_release", 32'({stall_f, stall_d, flush_e, flush_d}), 0); adv();
        clr(); reg_write_w = 1; rd_w = 6; rs2_e = 6;
        eval(); chk("lu_fwd_w", 32'(forward_b_e), 1); adv();

        // Branch wins over load-use
        clr(); reg_write_e = 1; result_src_e = 1; rd_e = 7; rs1_d = 7; pc_src_e = 1;
        eval(); chk("br_vs_hz", 32'({stall_f, stall_d, flush_d, flush_e}), 'h3); adv();

        // Memory wait: ready low 3 cycles then high
        clr(); reg_write_m1 = 1; result_src_m1 = 1; rd_m1 = 3; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            pc_src_e = (i == 1);
            eval();
            chk("mw_stall", 32'({dmem_req, stall_f, stall_d, stall_e, stall_m1, flush_m2}), 'h3F);
            chk("mw_noflush", 32'({flush_d, flush_e}), 0);
            adv();
        end
        pc_src_e = 0; dmem_ready = 1;
        eval(); chk("mw_done", 32'({dmem_req, stall_f, stall_d, stall_e, stall_m1, flush_m2}), 'h20); adv();
        clr();
        eval(); chk("mw_idle", 32'({dmem_req, stall_f, stall_m1}), 0); adv();

        // Timeout: store never acknowledged
        clr(); mem_write_m1 = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            eval(); chk("to_stall", 32'({dmem_req, stall_f, stall_m1}), 'h7); adv();
        end
        eval();
        chk("to_release", 32'({dmem_req, stall_f, stall_m1}), 'h4);
        chk("to_err_pre", 32'(dmem_err), 0);
        adv();
        clr();
        eval(); chk("to_err", 32'(dmem_err), 1); adv();
        eval(); chk("to_sticky", 32'(dmem_err), 1); adv();
        rst = 1; eval(); adv();
        rst = 0; eval(); chk("to_err_clr", 32'(dmem_err), 0); adv();

        // Reset during the second WAIT cycle
        clr(); reg_write_m1 = 1; result_src_m1 = 1; rd_m1 = 2; dmem_ready = 0;
        eval(); adv();
        eval(); adv();
        rst = 1;
        eval(); chk("rmw_rst", 32'({dmem_req, stall_f, stall_d, stall_e, stall_m1, flush_m2}), 0); adv();
        clr();
        eval(); chk("rmw_idle", 32'({dmem_req, stall_f, stall_m1, flush_m2}), 0); adv();
        mem_write_m1 = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            eval(); chk("rmw_restall", 32'(stall_f), 1); adv();
        end
        eval(); chk("rmw_cnt0", 32'(stall_f), 0); adv();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst           = ($urandom_range(0, 49) == 0);
            rs1_d         = 5'($urandom_range(0, 3));
            rs2_d         = 5'($urandom_range(0, 3));
            rs1_e         = 5'($urandom_range(0, 3));
            rs2_e         = 5'($urandom_range(0, 3));
            rd_e          = 5'($urandom_range(0, 3));
            rd_m1         = 5'($urandom_range(0, 3));
            rd_m2         = 5'($urandom_range(0, 3));
            rd_w          = 5'($urandom_range(0, 3));
            reg_write_e   = 1'($urandom_range(0, 1));
            reg_write_m1  = 1'($urandom_range(0, 1));
            reg_write_m2  = 1'($urandom_range(0, 1));
            reg_write_w   = 1'($urandom_range(0, 1));
            result_src_e  = 2'($urandom_range(0, 2));
            result_src_m1 = 2'($urandom_range(0, 2));
            mem_write_m1  = ($urandom_range(0, 3) == 0);
            pc_src_e      = ($urandom_range(0, 3) == 0);
            dmem_ready    = ($urandom_range(0, 3) == 0);
            eval();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
